// File: rtl/uart_tx_responder.sv
// Memory-mapped UART transmitter: TX FIFO, baud divider, status/control registers and
// an 8N1 serializer whose line output is registered one cycle behind the FSM state.
module uart_tx_responder #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  input  logic        bus_we_i,
  input  logic [1:0]  bus_hb_i,
  output logic [31:0] rdata_o,
  output logic        tx_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          tx_en_reg;
  logic          tx_reg;
  logic [15:0]   baud_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic [15:0]   div_value;

  logic [1:0]  sel;
  logic        wr_en;
  logic        div_we;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic        full;
  logic        empty;
  logic        busy;
  logic        bit_done;
  logic [3:0]  count4;
  logic [31:0] status_word;
  logic        unused_bits;

  assign sel      = bus_addr_i[3:2];
  assign wr_en    = cs_i & bus_we_i;
  assign div_we   = wr_en && (sel == 2'd2);
  assign full     = (count_reg == CW'(FIFO_DEPTH));
  assign empty    = (count_reg == '0);
  assign busy     = (state_reg != IDLE);
  assign push     = wr_en && (sel == 2'd0);
  assign push_ok  = push && !full;
  assign pop      = (state_reg == IDLE) && tx_en_reg && !empty;
  // Compared against the live divider so a DIV write retimes the bit in flight.
  assign bit_done = (baud_cnt_reg >= div_value);
  assign count4   = 4'(count_reg);
  assign tx_o     = tx_reg;

  assign unused_bits = ^{bus_addr_i[31:4], bus_addr_i[1:0], bus_wdata_i[31:16]};

  // Divider byte lanes: the low lane takes every DIV write, the high lane only half/word.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_div_lane
    logic [7:0] lane_reg;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        lane_reg <= DEFAULT_DIV[gi*8 +: 8];
      end else if (div_we && ((gi == 0) || (bus_hb_i != 2'b00))) begin
        lane_reg <= bus_wdata_i[gi*8 +: 8];
      end
    end
    assign div_value[gi*8 +: 8] = lane_reg;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= bus_wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      tx_en_reg    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      if (wr_en && (sel == 2'd1) && bus_wdata_i[3]) overflow_reg <= 1'b0;
      // A dropped push wins over a simultaneous clear so the loss is never hidden.
      if (push && full) overflow_reg <= 1'b1;
      if (wr_en && (sel == 2'd3)) tx_en_reg <= bus_wdata_i[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        START:   tx_reg <= 1'b0;
        DATA:    tx_reg <= shift_reg[0];
        default: tx_reg <= 1'b1;
      endcase

      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg    <= fifo_mem[rd_ptr_reg];
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            state_reg    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt_reg <= '0;
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {1'b0, shift_reg[7:1]};
            bit_idx_reg  <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
        default: begin
          if (bit_done) begin
            baud_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
      endcase
    end
  end

  assign status_word = {20'h0, count4, 4'h0, overflow_reg, busy, empty, full};

  always_comb begin
    rdata_o = 32'h0;
    if (cs_i && !bus_we_i) begin
      case (sel)
        2'd1:    rdata_o = status_word;
        2'd2:    rdata_o = {16'h0, div_value};
        2'd3:    rdata_o = {31'h0, tx_en_reg};
        default: rdata_o = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_responder.sv
// Register vector table, hand-timed frame/corner sequences and randomized traffic
// checked against a byte-queue and bit-period waveform model of the serial line.
module tb_uart_tx_responder;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  hb = 2'b00;
  logic [31:0] rdata;
  logic        tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cyc = 0;

  logic [7:0] exp_q[$];
  int         frame_starts[$];
  logic       mon_on = 1'b0;
  logic       mon_busy = 1'b0;
  int         mon_div = 3;
  logic       tx_log [0:32767];

  uart_tx_responder #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cs_i(cs), .bus_addr_i(addr), .bus_wdata_i(wdata),
    .bus_we_i(we), .bus_hb_i(hb), .rdata_o(rdata), .tx_o(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 32768) tx_log[cyc] <= tx;

  typedef struct {
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  hb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] h);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d; hb = h;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    wr_cyc = cyc;
  endtask

  // Issues a write whose capturing edge is the given edge number.
  task automatic write_at(input int e, input logic [31:0] a, input logic [31:0] d, input logic [1:0] h);
    while (cyc < e - 1) @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d; hb = h;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Line monitor: each frame is 10 bit periods of DIV+1 cycles (start 0, LSB-first data, stop 1).
  initial begin : monitor
    int         d;
    int         mism;
    int         bi;
    logic       has_exp;
    logic       e;
    logic [7:0] exp_b;
    logic [7:0] got_b;
    forever begin
      @(negedge clk);
      if (mon_on && tx === 1'b0) begin
        mon_busy = 1'b1;
        d = mon_div;
        frame_starts.push_back(cyc);
        has_exp = (exp_q.size() != 0);
        exp_b = has_exp ? exp_q.pop_front() : 8'h00;
        mism = 0;
        got_b = 8'h00;
        for (int i = 0; i < 10 * (d + 1); i++) begin
          if (i > 0) @(negedge clk);
          bi = i / (d + 1);
          e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : exp_b[bi-1];
          if (tx !== e) mism++;
          if (bi >= 1 && bi <= 8 && (i % (d + 1)) == d / 2) got_b[bi-1] = tx;
        end
        checks++;
        if (!has_exp || mism != 0) begin
          failures++;
          $display("FAIL frame@%0d: got byte %02h with %0d bad cycles (expected_present=%0d), required byte %02h",
                   frame_starts[$], got_b, mism, has_exp, exp_b);
        end else begin
          $display("ok   frame@%0d: byte %02h div %0d", frame_starts[$], got_b, d);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          w;
    int          nstart;
    int          mism;
    int          busy_bad;
    int          d;
    int          n;
    int          act;
    logic [31:0] st;
    logic [31:0] rw;
    logic [7:0]  b;
    logic        e;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          2'b10, 32'h0000_0002};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          2'b10, 32'h0000_0363};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,          2'b10, 32'h0000_0001};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          2'b10, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,          2'b10, 32'h0000_0000};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_1234,  2'b10, 32'h0000_0000};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          2'b10, 32'h0000_1234};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_00FF,  2'b00, 32'h0000_0000};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          2'b00, 32'h0000_12FF};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hABCD_0002,  2'b10, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          2'b10, 32'h0000_0002};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_5678,  2'b01, 32'h0000_0000};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFFB, 32'h0,          2'b10, 32'h0000_5678};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_000C, 32'hFFFF_FFFE,  2'b10, 32'h0000_0000};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,          2'b10, 32'h0000_0000};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_000C, 32'h0000_0003,  2'b00, 32'h0000_0000};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,          2'b00, 32'h0000_0001};
    vecs[17] = '{1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF,  2'b10, 32'h0000_0000};
    vecs[18] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          2'b10, 32'h0000_0002};
    vecs[19] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0003,  2'b10, 32'h0000_0000};
    vecs[20] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          2'b10, 32'h0000_0003};

    repeat (3) @(negedge clk);
    check("reset_tx", {31'h0, tx}, 32'h1);
    rst_ni = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      cs = vecs[i].cs; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata; hb = vecs[i].hb;
      #1;
      check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    check("idle_tx", {31'h0, tx}, 32'h1);

    // Single frame 0xA5 at DIV=3: timing of first fall, busy span, empty after pop.
    mon_div = 3; mon_on = 1'b1;
    exp_q.push_back(8'hA5);
    nstart = frame_starts.size();
    bus_write(32'h0, 32'hFFFF_FFA5, 2'b10);
    w = wr_cyc;
    cs = 1'b1; we = 1'b0; addr = 32'h4;
    #1;
    check("status_queued", rdata, 32'h0000_0100);
    busy_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (rdata[2] !== 1'b1) busy_bad++;
      if (k == 1) check("empty_after_pop", {31'h0, rdata[1]}, 32'h1);
    end
    check("busy_frame_bad_cycles", busy_bad, 32'd0);
    @(negedge clk);
    #1;
    check("status_after_frame", rdata, 32'h0000_0002);
    cs = 1'b0;
    wait_drain(200);
    act = (frame_starts.size() > nstart) ? frame_starts[nstart] : -1;
    check("first_fall_cycle", act, w + 2);

    // Overflow with transmit disabled, sticky clear, then ordered drain with 1-cycle gaps.
    bus_write(32'hC, 32'h0, 2'b10);
    nstart = frame_starts.size();
    for (int k = 0; k < 9; k++) bus_write(32'h0, k, 2'b00);
    bus_read(32'h4, st);
    check("status_overflow", st, 32'h0000_0809);
    check("tx_held_disabled", {31'h0, tx}, 32'h1);
    check("no_frame_disabled", frame_starts.size() - nstart, 32'd0);
    bus_write(32'h4, 32'h8, 2'b10);
    bus_read(32'h4, st);
    check("status_ovf_cleared", st, 32'h0000_0801);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(k));
    bus_write(32'hC, 32'h1, 2'b10);
    wait_drain(8 * 41 + 100);
    check("frames_sent", frame_starts.size() - nstart, 32'd8);
    if (frame_starts.size() - nstart == 8) begin
      for (int j = 1; j < 8; j++)
        check($sformatf("frame_gap%0d", j), frame_starts[nstart+j] - frame_starts[nstart+j-1], 32'd41);
    end
    bus_read(32'h4, st);
    check("status_drained", st, 32'h0000_0002);

    // DIV 7 -> 2 written mid-START with the baud counter at 5.
    mon_on = 1'b0;
    bus_write(32'h8, 32'h7, 2'b10);
    b = 8'h5A;
    bus_write(32'h0, {24'h0, b}, 2'b10);
    w = wr_cyc;
    write_at(w + 7, 32'h8, 32'h2, 2'b10);
    wait_until(w + 46);
    mism = 0;
    for (int c = w; c < w + 45; c++) begin
      if (c < w + 2)       e = 1'b1;
      else if (c < w + 9)  e = 1'b0;
      else if (c < w + 33) e = b[(c - (w + 9)) / 3];
      else                 e = 1'b1;
      if (tx_log[c] !== e) mism++;
    end
    check("div_retime_bad_cycles", mism, 32'd0);

    // Reset pulse during DATA bit 3 with a second byte still queued.
    bus_write(32'h8, 32'h3, 2'b10);
    bus_write(32'h0, 32'h0, 2'b10);
    w = wr_cyc;
    bus_write(32'h0, 32'h0, 2'b10);
    wait_until(w + 17);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    wait_until(w + 61);
    check("frame_running_before_rst", {31'h0, tx_log[w+17]}, 32'h0);
    mism = 0;
    for (int c = w + 18; c <= w + 60; c++) if (tx_log[c] !== 1'b1) mism++;
    check("tx_high_after_rst", mism, 32'd0);
    bus_read(32'h4, st);
    check("status_after_rst", st, 32'h0000_0002);
    bus_read(32'h8, st);
    check("div_after_rst", st, 32'h0000_0363);

    // Randomized traffic: random divider, burst length, access size and spacing.
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(0, 4);
      bus_write(32'h8, d, 2'b10);
      mon_div = d; mon_on = 1'b1;
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom());
        rw = $urandom();
        rw[7:0] = b;
        exp_q.push_back(b);
        bus_write({$urandom(), 2'b00} & 32'hFFFF_FFF3, rw, 2'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 12 * (d + 1))) @(negedge clk);
      end
      wait_drain(n * (10 * (d + 1) + 2) + 200);
      $display("round %0d: div %0d bytes %0d", r, d, n);
    end
    bus_read(32'h4, st);
    check("status_final", st, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_responder.md
UART_TX_RESPONDER -- requirements
Module: uart_tx_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: TX FIFO entries, a power of two.
REQ-002 Parameter DEFAULT_DIV, default 16'd867: reset value of DIV.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 cs_i  input  1  chip select, high when the bus decoder selects the UART region.
REQ-006 bus_addr_i  input  32  byte address; bits [3:2] select the register, other bits ignored.
REQ-007 bus_wdata_i  input  32  write data from the core.
REQ-008 bus_we_i  input  1  write enable.
REQ-009 bus_hb_i  input  2  access size: 00 byte, 01 half-word, 10/11 word.
REQ-010 rdata_o  output  32  read data to the bus, driven combinationally.
REQ-011 tx_o  output  1  serial line, idle high.

Function
REQ-012 Register map (addr[3:2]):
- 0 TXDATA: write-only; reads 0.
- 1 STATUS: read, plus write-1-clear of bit3. Bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[11:8] FIFO count, other bits 0.
- 2 DIV: read/write; bits[15:0], upper bits read 0.
- 3 CTRL: read/write; bit0 tx_en, other bits read 0.
REQ-013 A write occurs on a clock edge with cs_i=1 and bus_we_i=1; its effect is visible from the next cycle.
REQ-014 rdata_o SHALL be the selected register when cs_i=1 and bus_we_i=0, else 32'h0; reads have no side effects.
REQ-015 A TXDATA write SHALL push bus_wdata_i[7:0] regardless of bus_hb_i.
REQ-016 DIV byte writes update [7:0] only; half and word writes update [15:0].
REQ-017 Full is judged on the pre-edge count. A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
REQ-018 A push and a pop on the same edge with 0<count<FIFO_DEPTH leave count unchanged; FIFO order is preserved.
REQ-019 Bit period SHALL be DIV+1 clocks, timed by a baud counter compared against the live DIV.
- A DIV write mid-bit takes effect for the current bit.
- If the counter already equals or exceeds the new DIV, the bit ends on the next edge.
REQ-020 FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE: tx_o=1.
- When tx_en=1 and the FIFO is non-empty, pop the head into the shift register, clear the baud counter and bit index, and go to START.
REQ-022 START: tx_o=0 for one bit period, then go to DATA.
REQ-023 DATA: tx_o=shift[0] per bit period, LSB first; after 8 bits go to STOP.
REQ-024 STOP: tx_o=1 for one bit period, then go to IDLE.
- This yields exactly one IDLE cycle between back-to-back frames.
REQ-025 Clearing tx_en mid-frame SHALL NOT abort the frame; only the next pop is blocked.
REQ-026 tx_o SHALL be driven from a register (glitch-free).
REQ-027 Frame length SHALL be 10*(DIV+1) cycles.
- tx_o falls 1 cycle after the pop edge, i.e. 2 cycles after the TXDATA write edge into an empty FIFO in IDLE.

Reset
REQ-028 When rst_ni=0 at a clock edge:
- FIFO emptied (count 0, pointers 0), overflow=0.
- FSM=IDLE, baud counter and bit index 0, tx_o=1.
- DIV=DEFAULT_DIV, CTRL=32'h1.
REQ-029 Reset asserted mid-frame SHALL force tx_o=1 on the next edge; the frame is abandoned and no partial byte is re-sent.
REQ-030 rdata_o after reset SHALL reflect reset values: STATUS=32'h2, DIV=867, CTRL=1.

Verification
REQ-031 Reset then read STATUS/DIV/CTRL -> 32'h2, 32'h363, 32'h1; tx_o=1.
REQ-032 DIV=3, write TXDATA 0xA5 -> tx_o low at write edge+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; busy=1 throughout; empty=1 after the pop.
REQ-033 DIV=3, CTRL=0, write 9 bytes 0x00..0x08 -> count=8, full=1, overflow=1, tx_o stays 1.
- Write STATUS 0x8 -> overflow=0.
- Set CTRL=1 -> bytes 0x00..0x07 sent in order, each frame 40 cycles, 1-cycle IDLE gap between frames.
REQ-034 Byte write 0xFF with addr offset 8 while DIV=0x1234 -> DIV=0x12FF; word write 0xABCD0002 -> DIV=0x0002.
REQ-035 DIV=3, rst_ni=0 for one edge during DATA bit 3 -> tx_o=1, STATUS=0x2, FIFO empty, no further toggling.
REQ-036 DIV=7, mid-START at counter=5 write DIV=2 -> START ends on the next edge; subsequent bits last 3 cycles.
